// File: rtl/stage_sequencer.sv
// Launch-vehicle staging controller: per-stage config table, saturating initial-weight
// accumulation, and IGNITE/BURN/SEP/COAST sequencing of the engine model with fault/abort handling.
module stage_sequencer #(
   parameter int NUM_STAGES    = 4,
   parameter int N             = 64,
   parameter int SW            = 2,
   parameter int TICKS_PER_SEC = 1000,
   parameter int BURN_MARGIN   = 16,
   parameter int COAST_CYCLES  = 2
) (
   input  logic          clk,
   input  logic          resetb,
   input  logic          cfg_we,
   input  logic [SW-1:0] cfg_stage,
   input  logic [2:0]    cfg_field,
   input  logic [N-1:0]  cfg_data,
   input  logic [N-1:0]  payload_weight,
   input  logic          launch,
   input  logic          abort,
   input  logic          burn_done,
   output logic          engine_resetb,
   output logic [N-1:0]  isp,
   output logic [N-1:0]  initial_weight,
   output logic [N-1:0]  propellant_weight,
   output logic [N-1:0]  burn_time,
   output logic [SW-1:0] stage_idx,
   output logic [2:0]    state,
   output logic          stage_start,
   output logic          sep_pulse,
   output logic          busy,
   output logic          mission_done,
   output logic          fault,
   output logic          sat,
   output logic          cfg_err
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_IGNITE = 3'd2,
      S_BURN   = 3'd3,
      S_SEP    = 3'd4,
      S_COAST  = 3'd5,
      S_DONE   = 3'd6,
      S_HALT   = 3'd7
   } state_t;

   localparam logic [SW-1:0] LAST = SW'(NUM_STAGES - 1);

   state_t          state_q;
   logic [N-1:0]    isp_tbl  [NUM_STAGES];
   logic [N-1:0]    prop_tbl [NUM_STAGES];
   logic [N-1:0]    dry_tbl  [NUM_STAGES];
   logic [N-1:0]    bt_tbl   [NUM_STAGES];
   logic [NUM_STAGES-1:0] sep_tbl;

   logic [SW-1:0]   load_j;
   logic [N-1:0]    acc;
   logic [N-1:0]    cnt;
   logic [N-1:0]    burn_limit;

   logic [N-1:0]    load_base;
   logic [N+1:0]    load_sum;
   logic            load_ovf;
   logic [N-1:0]    load_val;
   logic            cfg_ok;
   logic            coast_over;

   assign state = state_q;
   assign busy  = (state_q == S_LOAD) || (state_q == S_IGNITE) || (state_q == S_BURN) ||
                  (state_q == S_SEP)  || (state_q == S_COAST);

   // NOTE: every variable driven here gets a value on every path, so no latch is inferred.
   always_comb begin
      load_base  = (load_j == LAST) ? payload_weight : acc;
      load_sum   = {2'b00, load_base} + {2'b00, prop_tbl[load_j]} + {2'b00, dry_tbl[load_j]};
      load_ovf   = |load_sum[N+1:N];
      load_val   = load_ovf ? '1 : load_sum[N-1:0];
      cfg_ok     = (32'(cfg_stage) < NUM_STAGES) && (cfg_field <= 3'd4);
      coast_over = ((state_q == S_SEP) && (COAST_CYCLES == 0)) ||
                   ((state_q == S_COAST) && (cnt == N'(COAST_CYCLES - 1)));
   end

   // NOTE: the config table is reset like any other state because a reset must clear it.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         for (int i = 0; i < NUM_STAGES; i++) begin
            isp_tbl[i]  <= '0;
            prop_tbl[i] <= '0;
            dry_tbl[i]  <= '0;
            bt_tbl[i]   <= '0;
         end
         sep_tbl <= '0;
         cfg_err <= 1'b0;
      end else begin
         cfg_err <= cfg_we && (busy || !cfg_ok);
         if (cfg_we && !busy && cfg_ok) begin
            case (cfg_field)
               3'd0:    isp_tbl[cfg_stage]  <= cfg_data;
               3'd1:    prop_tbl[cfg_stage] <= cfg_data;
               3'd2:    dry_tbl[cfg_stage]  <= cfg_data;
               3'd3:    bt_tbl[cfg_stage]   <= cfg_data;
               default: sep_tbl[cfg_stage]  <= cfg_data[0];
            endcase
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state_q           <= S_IDLE;
         engine_resetb     <= 1'b0;
         isp               <= '0;
         initial_weight    <= '0;
         propellant_weight <= '0;
         burn_time         <= '0;
         stage_idx         <= '0;
         stage_start       <= 1'b0;
         sep_pulse         <= 1'b0;
         mission_done      <= 1'b0;
         fault             <= 1'b0;
         sat               <= 1'b0;
         load_j            <= '0;
         acc               <= '0;
         cnt               <= '0;
         burn_limit        <= '0;
      end else if (busy && abort) begin
         state_q       <= S_HALT;
         engine_resetb <= 1'b0;
         stage_start   <= 1'b0;
         sep_pulse     <= 1'b0;
      end else if (!busy && launch) begin
         state_q      <= S_LOAD;
         stage_idx    <= '0;
         load_j       <= LAST;
         fault        <= 1'b0;
         mission_done <= 1'b0;
         sat          <= 1'b0;
      end else begin
         case (state_q)
            S_LOAD: begin
               acc <= load_val;
               if (load_ovf) sat <= 1'b1;
               if (load_j == stage_idx) begin
                  isp               <= isp_tbl[load_j];
                  propellant_weight <= prop_tbl[load_j];
                  burn_time         <= bt_tbl[load_j];
                  initial_weight    <= load_val;
                  burn_limit        <= bt_tbl[load_j] * N'(TICKS_PER_SEC) + N'(BURN_MARGIN);
                  stage_start       <= 1'b1;
                  state_q           <= S_IGNITE;
               end else begin
                  load_j <= load_j - 1'b1;
               end
            end
            S_IGNITE: begin
               stage_start   <= 1'b0;
               engine_resetb <= 1'b1;
               cnt           <= '0;
               state_q       <= S_BURN;
            end
            S_BURN: begin
               if (burn_done) begin
                  sep_pulse     <= sep_tbl[stage_idx];
                  engine_resetb <= 1'b0;
                  state_q       <= S_SEP;
               end else if (cnt == burn_limit) begin
                  fault         <= 1'b1;
                  engine_resetb <= 1'b0;
                  state_q       <= S_HALT;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_SEP, S_COAST: begin
               sep_pulse <= 1'b0;
               if (coast_over) begin
                  if (stage_idx == LAST) begin
                     mission_done <= 1'b1;
                     state_q      <= S_DONE;
                  end else begin
                     stage_idx <= stage_idx + 1'b1;
                     load_j    <= LAST;
                     state_q   <= S_LOAD;
                  end
               end else if (state_q == S_SEP) begin
                  cnt     <= '0;
                  state_q <= S_COAST;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed/randomized bench for stage_sequencer; expected weights, latencies and flags
// come from a plain-arithmetic model of the staging rules.
module tb_stage_sequencer;
   localparam int NS  = 4;
   localparam int N   = 64;
   localparam int SW  = 2;
   localparam int TPS = 1000;
   localparam int BM  = 16;
   localparam int CC  = 2;

   localparam logic [2:0] ST_IDLE = 3'd0, ST_LOAD = 3'd1, ST_IGNITE = 3'd2, ST_BURN = 3'd3,
                          ST_SEP = 3'd4, ST_COAST = 3'd5, ST_DONE = 3'd6, ST_HALT = 3'd7;

   logic          clk = 1'b0;
   logic          resetb;
   logic          cfg_we;
   logic [SW-1:0] cfg_stage;
   logic [2:0]    cfg_field;
   logic [N-1:0]  cfg_data;
   logic [N-1:0]  payload_weight;
   logic          launch, abort, burn_done;
   logic          engine_resetb;
   logic [N-1:0]  isp, initial_weight, propellant_weight, burn_time;
   logic [SW-1:0] stage_idx;
   logic [2:0]    state;
   logic          stage_start, sep_pulse, busy, mission_done, fault, sat, cfg_err;

   stage_sequencer #(
      .NUM_STAGES(NS), .N(N), .SW(SW), .TICKS_PER_SEC(TPS), .BURN_MARGIN(BM), .COAST_CYCLES(CC)
   ) dut (
      .clk(clk), .resetb(resetb), .cfg_we(cfg_we), .cfg_stage(cfg_stage), .cfg_field(cfg_field),
      .cfg_data(cfg_data), .payload_weight(payload_weight), .launch(launch), .abort(abort),
      .burn_done(burn_done), .engine_resetb(engine_resetb), .isp(isp), .initial_weight(initial_weight),
      .propellant_weight(propellant_weight), .burn_time(burn_time), .stage_idx(stage_idx),
      .state(state), .stage_start(stage_start), .sep_pulse(sep_pulse), .busy(busy),
      .mission_done(mission_done), .fault(fault), .sat(sat), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference configuration table as the bench believes it to be.
   logic [N-1:0] m_isp [NS];
   logic [N-1:0] m_prop[NS];
   logic [N-1:0] m_dry [NS];
   logic [N-1:0] m_bt  [NS];
   logic         m_sep [NS];

   task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Payload plus every stage from k upward, clipped at the N-bit maximum.
   function automatic logic [N-1:0] exp_iw(input int k);
      logic [N+7:0] total;
      total = {8'd0, payload_weight};
      for (int j = k; j < NS; j++) total = total + {8'd0, m_prop[j]} + {8'd0, m_dry[j]};
      if (total > {8'd0, {N{1'b1}}}) return '1;
      return total[N-1:0];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input int stg, input int fld, input logic [N-1:0] data);
      cfg_we    = 1'b1;
      cfg_stage = SW'(stg);
      cfg_field = 3'(fld);
      cfg_data  = data;
      step();
      cfg_we = 1'b0;
      case (fld)
         0: m_isp[stg]  = data;
         1: m_prop[stg] = data;
         2: m_dry[stg]  = data;
         3: m_bt[stg]   = data;
         4: m_sep[stg]  = data[0];
         default: ;
      endcase
   endtask

   task automatic wait_stage_start(input int expected);
      int n = 0;
      while (!stage_start && n < 50) begin
         step();
         n++;
      end
      check("load_cycles", N'(n), N'(expected));
   endtask

   task automatic launch_seq();
      launch = 1'b1;
      step();
      launch = 1'b0;
      check("launch_to_load", N'(state), N'(ST_LOAD));
   endtask

   task automatic run_mission();
      launch_seq();
      check("launch_clears_done", N'(mission_done), '0);
      for (int k = 0; k < NS; k++) begin
         wait_stage_start(NS - k);
         check($sformatf("iw_s%0d", k), initial_weight, exp_iw(k));
         check($sformatf("isp_s%0d", k), isp, m_isp[k]);
         check($sformatf("prop_s%0d", k), propellant_weight, m_prop[k]);
         check($sformatf("bt_s%0d", k), burn_time, m_bt[k]);
         check($sformatf("idx_s%0d", k), N'(stage_idx), N'(k));
         check($sformatf("ign_eng_s%0d", k), N'(engine_resetb), '0);
         step();
         check($sformatf("burn_state_s%0d", k), N'(state), N'(ST_BURN));
         check($sformatf("burn_eng_s%0d", k), N'(engine_resetb), N'(1));
         if (k == 1) begin
            cfg_we = 1'b1; cfg_stage = 2'd3; cfg_field = 3'd1; cfg_data = ~m_prop[3];
            step();
            cfg_we = 1'b0;
            check("busy_cfg_err", N'(cfg_err), N'(1));
            step();
            check("busy_cfg_err_pulse", N'(cfg_err), '0);
         end
         repeat ($urandom_range(0, 10)) step();
         check($sformatf("still_burn_s%0d", k), N'(state), N'(ST_BURN));
         burn_done = 1'b1;
         step();
         burn_done = 1'b0;
         check($sformatf("sep_state_s%0d", k), N'(state), N'(ST_SEP));
         check($sformatf("sep_pulse_s%0d", k), N'(sep_pulse), N'(m_sep[k]));
         check($sformatf("sep_eng_s%0d", k), N'(engine_resetb), '0);
         for (int c = 0; c < CC; c++) begin
            step();
            check($sformatf("coast_s%0d", k), N'(state), N'(ST_COAST));
            check($sformatf("coast_nosep_s%0d", k), N'(sep_pulse), '0);
         end
         step();
         if (k < NS - 1) check($sformatf("next_load_s%0d", k), N'(state), N'(ST_LOAD));
      end
      check("done_state", N'(state), N'(ST_DONE));
      check("mission_done", N'(mission_done), N'(1));
      check("done_busy", N'(busy), '0);
      check("done_eng", N'(engine_resetb), '0);
   endtask

   initial begin
      int n;
      resetb = 1'b0; cfg_we = 1'b0; cfg_stage = '0; cfg_field = '0; cfg_data = '0;
      payload_weight = '0; launch = 1'b0; abort = 1'b0; burn_done = 1'b0;
      for (int i = 0; i < NS; i++) begin
         m_isp[i] = '0; m_prop[i] = '0; m_dry[i] = '0; m_bt[i] = '0; m_sep[i] = 1'b0;
      end
      repeat (2) @(posedge clk);
      #1;
      check("rst_state", N'(state), N'(ST_IDLE));
      check("rst_iw", initial_weight, '0);
      check("rst_isp", isp, '0);
      check("rst_eng", N'(engine_resetb), '0);
      check("rst_flags", N'({busy, mission_done, fault, sat, cfg_err, stage_start, sep_pulse}), '0);
      #3 resetb = 1'b1;
      step();

      // Nominal vehicle from the reference data, with random Isp and burn times.
      payload_weight = 64'd27003;
      cfg_write(0, 1, 64'd2077000); cfg_write(1, 1, 64'd456100);
      cfg_write(2, 1, 64'd39136);   cfg_write(3, 1, 64'd83864);
      cfg_write(0, 2, 64'd137000);  cfg_write(1, 2, 64'd40100);
      cfg_write(2, 2, 64'd0);       cfg_write(3, 2, 64'd15200);
      for (int i = 0; i < NS; i++) begin
         cfg_write(i, 0, {$urandom, $urandom});
         cfg_write(i, 3, N'($urandom_range(1, 4)));
         cfg_write(i, 4, N'((i == 2) ? 0 : 1));
      end
      check("ref_iw0", exp_iw(0), 64'd2875403);
      check("ref_iw1", exp_iw(1), 64'd661403);
      run_mission();

      // Illegal field while idle.
      cfg_we = 1'b1; cfg_stage = 2'd0; cfg_field = 3'd5; cfg_data = 64'd99;
      step();
      cfg_we = 1'b0;
      check("bad_field_err", N'(cfg_err), N'(1));
      step();
      check("bad_field_err_pulse", N'(cfg_err), '0);

      // Burn timeout on stage 0 with a 1 s burn and no burn_done.
      cfg_write(0, 3, 64'd1);
      launch_seq();
      wait_stage_start(NS);
      step();
      n = 0;
      while (state == ST_BURN && n < 1100) begin
         step();
         n++;
      end
      check("timeout_cycles", N'(n), N'(1 * TPS + BM + 1));
      check("timeout_state", N'(state), N'(ST_HALT));
      check("timeout_fault", N'(fault), N'(1));
      check("timeout_eng", N'(engine_resetb), '0);

      // Abort beats burn_done in the same BURN cycle.
      cfg_write(0, 3, 64'd2);
      launch_seq();
      check("relaunch_fault_clr", N'(fault), '0);
      wait_stage_start(NS);
      step();
      repeat (3) step();
      abort = 1'b1; burn_done = 1'b1;
      step();
      abort = 1'b0; burn_done = 1'b0;
      check("abort_state", N'(state), N'(ST_HALT));
      check("abort_fault", N'(fault), '0);
      check("abort_nosep", N'(sep_pulse), '0);

      // Launch with abort: launch wins when idle, abort wins when busy.
      launch = 1'b1; abort = 1'b1;
      step();
      check("launch_beats_abort", N'(state), N'(ST_LOAD));
      step();
      launch = 1'b0; abort = 1'b0;
      check("abort_beats_launch", N'(state), N'(ST_HALT));

      // Saturating initial weight.
      cfg_write(3, 2, '1);
      launch_seq();
      wait_stage_start(NS);
      check("sat_iw", initial_weight, exp_iw(0));
      check("sat_flag", N'(sat), N'(1));

      // Reset mid-sequence clears outputs and the table.
      step();
      resetb = 1'b0;
      #1;
      check("midrst_state", N'(state), N'(ST_IDLE));
      check("midrst_iw", initial_weight, '0);
      check("midrst_sat", N'(sat), '0);
      check("midrst_eng", N'(engine_resetb), '0);
      #3 resetb = 1'b1;
      for (int i = 0; i < NS; i++) begin
         m_isp[i] = '0; m_prop[i] = '0; m_dry[i] = '0; m_bt[i] = '0; m_sep[i] = 1'b0;
      end
      step();
      payload_weight = N'($urandom_range(1, 1000000));
      launch_seq();
      wait_stage_start(NS);
      check("cleared_tbl_iw", initial_weight, exp_iw(0));
      check("cleared_tbl_isp", isp, '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
